// File: rtl/time_set_pkg.sv
// Shared types and BCD helpers for the time/alarm set controller.
// Edit states, edit_field codes and BCD limits live here.
package time_set_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_HOUR,
        S_T_MIN,
        S_T_COMMIT,
        S_A_HOUR,
        S_A_MIN,
        S_A_COMMIT
    } state_e;

    localparam logic [1:0] EF_NONE = 2'd0;
    localparam logic [1:0] EF_HOUR = 2'd1;
    localparam logic [1:0] EF_MIN  = 2'd2;

    localparam logic [1:0] H_TENS_MAX  = 2'd2;
    localparam logic [3:0] H_UNITS_TOP = 4'd3;
    localparam logic [3:0] M_TENS_MAX  = 4'd5;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    // 23 wraps to 00; units roll into tens at 9.
    function automatic bcd_time_t inc_hour(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.h1 == H_TENS_MAX && t.h0 == H_UNITS_TOP) begin
            r.h1 = '0;
            r.h0 = '0;
        end else if (t.h0 >= BCD_MAX) begin
            r.h0 = '0;
            r.h1 = t.h1 + 2'd1;
        end else begin
            r.h0 = t.h0 + 4'd1;
        end
        return r;
    endfunction

    // 59 wraps to 00; hours are never touched.
    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m0 >= BCD_MAX) begin
            r.m0 = '0;
            if (t.m1 >= M_TENS_MAX) r.m1 = '0;
            else r.m1 = t.m1 + 4'd1;
        end else begin
            r.m0 = t.m0 + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_cond.sv
// Button conditioner: 2-flop sync, optional debounce, edge pulse.
// Debounce is built only when TSC_DEBOUNCE_EN is defined.
module btn_cond #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    logic [1:0] sync;
    logic       lvl_q;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else sync <= {sync[0], btn_raw};
    end

`ifdef TSC_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYC + 1);

    logic [CW-1:0] deb_cnt;
    logic          stable;

    // Accept a new level after DEB_CYC matching samples in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable  <= 1'b0;
            deb_cnt <= '0;
        end else if (sync[1] == stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYC - 1)) begin
            stable  <= sync[1];
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CW'(1);
        end
    end

    assign level = stable;
`else
    logic deb_unused;
    assign deb_unused = (DEB_CYC > 0);
    assign level = sync[1];
`endif

    // One-cycle pulse on each accepted rising level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q <= 1'b0;
            press <= 1'b0;
        end else begin
            lvl_q <= level;
            press <= level & ~lvl_q;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Push-button edit front end for the alarm clock load ports.
// Define TSC_DEBOUNCE_EN to insert a debounce stage per button.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEB_CYC     = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [3:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       AL_on,
    output logic       STOP_al,
    output logic [1:0] edit_field
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          p_time, p_alarm, p_inc, p_stop_unused;
    logic [2:0]    lvl_unused;
    logic          stop_lvl;
    logic          pt, pa, pi, any_press;
    logic          in_edit, timed_out;

    state_e        state_q, state_d;
    bcd_time_t     stage_q, stage_d;
    bcd_time_t     shadow_q, shadow_d;
    bcd_time_t     cur_t;
    logic          al_on_q, al_on_d;
    logic [TW-1:0] idle_q, idle_d;

    btn_cond #(.DEB_CYC(DEB_CYC)) u_time (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_time),
        .level(lvl_unused[0]), .press(p_time)
    );
    btn_cond #(.DEB_CYC(DEB_CYC)) u_alarm (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_alarm),
        .level(lvl_unused[1]), .press(p_alarm)
    );
    btn_cond #(.DEB_CYC(DEB_CYC)) u_inc (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_inc),
        .level(lvl_unused[2]), .press(p_inc)
    );
    btn_cond #(.DEB_CYC(DEB_CYC)) u_stop (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_stop),
        .level(stop_lvl), .press(p_stop_unused)
    );

    // Same-cycle presses resolve time > alarm > inc
    assign pt        = p_time;
    assign pa        = p_alarm & ~p_time;
    assign pi        = p_inc & ~p_time & ~p_alarm;
    assign any_press = p_time | p_alarm | p_inc;

    assign cur_t = {cur_H1, cur_H0, cur_M1, cur_M0};

    assign in_edit = (state_q == S_T_HOUR) || (state_q == S_T_MIN) ||
                     (state_q == S_A_HOUR) || (state_q == S_A_MIN);
    assign timed_out = in_edit && !any_press &&
                       (idle_q == TW'(TIMEOUT_CYC - 1));

    // State, stage, alarm shadow, enable and idle timer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            shadow_q <= '0;
            al_on_q  <= 1'b0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
            al_on_q  <= al_on_d;
            idle_q   <= idle_d;
        end
    end

    // Next-state, stage edits, strobes and field indicator
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        shadow_d   = shadow_q;
        al_on_d    = al_on_q;
        idle_d     = '0;
        LD_time    = 1'b0;
        LD_alarm   = 1'b0;
        edit_field = EF_NONE;

        if (in_edit && !any_press && !timed_out)
            idle_d = idle_q + TW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (pt) begin
                    stage_d = cur_t;
                    state_d = S_T_HOUR;
                end else if (pa) begin
                    stage_d = shadow_q;
                    state_d = S_A_HOUR;
                end else if (pi) begin
                    al_on_d = ~al_on_q;
                end
            end
            S_T_HOUR: begin
                edit_field = EF_HOUR;
                if (pt) state_d = S_T_MIN;
                else if (pi) stage_d = inc_hour(stage_q);
                else if (timed_out) state_d = S_IDLE;
            end
            S_T_MIN: begin
                edit_field = EF_MIN;
                if (pt) state_d = S_T_COMMIT;
                else if (pi) stage_d = inc_min(stage_q);
                else if (timed_out) state_d = S_IDLE;
            end
            S_T_COMMIT: begin
                LD_time = 1'b1;
                state_d = S_IDLE;
            end
            S_A_HOUR: begin
                edit_field = EF_HOUR;
                if (pa) state_d = S_A_MIN;
                else if (pi) stage_d = inc_hour(stage_q);
                else if (timed_out) state_d = S_IDLE;
            end
            S_A_MIN: begin
                edit_field = EF_MIN;
                if (pa) state_d = S_A_COMMIT;
                else if (pi) stage_d = inc_min(stage_q);
                else if (timed_out) state_d = S_IDLE;
            end
            S_A_COMMIT: begin
                LD_alarm = 1'b1;
                shadow_d = stage_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign H_in1   = stage_q.h1;
    assign H_in0   = stage_q.h0;
    assign M_in1   = stage_q.m1;
    assign M_in0   = stage_q.m0;
    assign AL_on   = al_on_q;
    assign STOP_al = stop_lvl;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Push-button front end that drives the load side of `Alarm_clock`. It conditions four raw buttons and runs an edit state machine over staged hour/minute BCD fields, pre-loading them from the clock's current time outputs. It then commits them with a single-cycle `LD_time` or `LD_alarm` strobe. It also generates the `AL_on` level and the `STOP_al` request.

## Interface
- `DEB_CYC`, 16: stable cycles required before a button level is accepted (only used with debounce enabled).
- `TIMEOUT_CYC`, 1000: idle cycles in any edit state before the edit is aborted.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_time` input 1: raw button; enter, advance or commit a time edit.
- `btn_alarm` input 1: raw button; enter, advance or commit an alarm edit.
- `btn_inc` input 1: raw button; increment the field being edited, or toggle `AL_on` when in IDLE.
- `btn_stop` input 1: raw button, level; requests that the alarm stop.
- `cur_H1` input 2: current-time BCD hour tens from the clock.
- `cur_H0` input 4: current-time BCD hour units from the clock.
- `cur_M1` input 4: current-time BCD minute tens from the clock.
- `cur_M0` input 4: current-time BCD minute units from the clock.
- `H_in1` output 2: staged BCD hour tens, wired to the clock.
- `H_in0` output 4: staged BCD hour units, wired to the clock.
- `M_in1` output 4: staged BCD minute tens, wired to the clock.
- `M_in0` output 4: staged BCD minute units, wired to the clock.
- `LD_time` output 1: one-cycle load strobe for the time registers.
- `LD_alarm` output 1: one-cycle load strobe for the alarm registers.
- `AL_on` output 1: alarm enable level.
- `STOP_al` output 1: conditioned `btn_stop` level.
- `edit_field` output 2: 0 = none, 1 = hours, 2 = minutes; intended for display blink.

## Operation
- **Button conditioning**
  - Each button passes through a 2-flop synchronizer, then the optional debounce, then a rising-edge detector.
  - The result is a one-cycle press pulse per button.
  - `STOP_al` follows the conditioned level of `btn_stop`, not its pulse.
- **States:** IDLE, T_HOUR, T_MIN, T_COMMIT, A_HOUR, A_MIN, A_COMMIT.
- **From IDLE:**
  - A time press loads the stage from `cur_*`, then goes to T_HOUR.
  - An alarm press loads the stage from the internal alarm shadow, then goes to A_HOUR.
  - An inc press toggles `AL_on`.
- **Time edit path:** T_HOUR → T_MIN on a time press; T_MIN → T_COMMIT on a time press.
- **Alarm edit path:** A_HOUR → A_MIN on an alarm press; A_MIN → A_COMMIT on an alarm press.
- **Other presses during an edit:** the opposite-mode button is ignored in edit states. An inc press increments the current field.
- **COMMIT states:**
  - T_COMMIT asserts `LD_time` for exactly one cycle.
  - A_COMMIT asserts `LD_alarm` for exactly one cycle and copies the stage into the alarm shadow.
  - Both return to IDLE on the next cycle.
- **Hour increment (BCD):** 09→10, 19→20, 23→00. `H_in0` never exceeds 9.
- **Minute increment (BCD):** x9→(x+1)0, 59→00. There is no carry into hours.
- **Simultaneous presses in the same cycle:** priority is time, then alarm, then inc. Lower-priority presses are dropped.
- **Edit timeout:** the idle counter clears on any press.
  - When it reaches `TIMEOUT_CYC` in T_HOUR, T_MIN, A_HOUR or A_MIN, the state returns to IDLE with no strobe.
  - The stage and alarm shadow are left unchanged.
- **Stage outputs:** `H_in*`/`M_in*` always present the stage. They hold their value after a commit and after an abort.
- **Reset** (mid-edit included) takes effect immediately and asynchronously:
  - state = IDLE;
  - stage = 00:00;
  - alarm shadow = 00:00;
  - `LD_time` = `LD_alarm` = `AL_on` = `STOP_al` = 0;
  - `edit_field` = 0;
  - all counters = 0.

## Timing
- **Raw press to pulse:** 2 synchronizer cycles, plus `DEB_CYC` stable cycles when debounce is enabled, plus 1 edge cycle.
- **Pulse in cycle N:** the state and stage update is visible in cycle N+1.
- **Commit:** the strobe is high during the cycle spent in the COMMIT state. The stage is stable in that cycle and in the cycles around it.
- **Re-entry:** a new edit press is accepted starting in the first cycle after the return to IDLE.
- **Debounce counter:** restarts on every level change. Bounces shorter than `DEB_CYC` produce no pulse.

## Configuration
- `TSC_DEBOUNCE_EN` defined: a debounce counter (`$clog2(DEB_CYC+1)` bits) sits between the synchronizer and the edge detector.
- `TSC_DEBOUNCE_EN` undefined: the synchronizer output feeds the edge detector directly. `DEB_CYC` is unused, and latency is 3 cycles.

## Structure
- **Package `time_set_pkg`:** state enum; `edit_field` encodings; BCD limit constants (hour tens max 2, hour max 23, minute tens max 5).
- **Sub-module `btn_cond`:** synchronizer, optional debounce and edge detect. Instantiated four times; outputs both the level and the press pulse.

## Test plan
- **Reset:** reset_n low mid-T_MIN → all outputs 0 immediately; after release, state is IDLE and stage is 00:00.
- **Time set:** `cur_*` = 10:18; time press, 2× inc, time press, 3× inc, time press → `LD_time` high for exactly 1 cycle with H=12, M=21.
- **Wrap:** stage 23:59; one inc in hours → 00; one inc in minutes → 00, hours still 00.
- **Alarm and enable:**
  - Alarm press, inc to 10:28, alarm press ×2 → `LD_alarm` pulse.
  - Re-enter alarm edit → stage reloads 10:28.
  - Inc press in IDLE → `AL_on` = 1.
- **Timeout and priority:**
  - Enter T_HOUR and wait `TIMEOUT_CYC` → IDLE, no strobe.
  - Time and alarm pressed in the same cycle from IDLE → T_HOUR.
- **Debounce:** with `TSC_DEBOUNCE_EN`, `DEB_CYC`=16, a 10-cycle glitch on `btn_inc` → no increment; a 20-cycle hold → exactly one increment. `STOP_al` tracks `btn_stop` level.
